// File: rtl/pi1_rr_arbiter_pkg.sv
// pi1 shared definitions: op encodings and width helpers
// used by the round-robin arbiter and its picker.
package pi1_rr_arbiter_pkg;

  localparam logic [1:0] PINOOP = 2'b00;
  localparam logic [1:0] PIWROP = 2'b01;
  localparam logic [1:0] PIRDOP = 2'b10;
  localparam logic [1:0] PIRWOP = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int addr_bits(input int arch);
    return arch - clog2(arch / 8);
  endfunction

  function automatic int idx_bits(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pi1_rr_arbiter_if.sv
// pi1 bundle seen by the arbiter: MASTERCOUNT upstream
// master ports plus the single downstream slave port.
interface pi1_rr_arbiter_if #(
  parameter int MASTERCOUNT = 4,
  parameter int ARCHBITSZ   = 16
);
  import pi1_rr_arbiter_pkg::*;

  localparam int ADDRBITSZ = addr_bits(ARCHBITSZ);
  localparam int SELBITSZ  = ARCHBITSZ / 8;

  logic [2*MASTERCOUNT-1:0]         m_op_i;
  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i;
  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i;
  logic [SELBITSZ*MASTERCOUNT-1:0]  m_sel_i;
  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_o;
  logic [MASTERCOUNT-1:0]           m_rdy_o;
  logic [1:0]                       s_op_o;
  logic [ADDRBITSZ-1:0]             s_addr_o;
  logic [ARCHBITSZ-1:0]             s_data_o;
  logic [SELBITSZ-1:0]              s_sel_o;
  logic [ARCHBITSZ-1:0]             s_data_i;
  logic                             s_rdy_i;

  modport master (
    output m_op_i, m_addr_i, m_data_i, m_sel_i,
    output s_data_i, s_rdy_i,
    input  m_data_o, m_rdy_o,
    input  s_op_o, s_addr_o, s_data_o, s_sel_o
  );

  modport slave (
    input  m_op_i, m_addr_i, m_data_i, m_sel_i,
    input  s_data_i, s_rdy_i,
    output m_data_o, m_rdy_o,
    output s_op_o, s_addr_o, s_data_o, s_sel_o
  );

endinterface

// File: rtl/pi1_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after
// last, wrapping around.
module pi1_rr_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] pick_o,
  output logic          valid_o
);

  logic [IW-1:0] idx;

  // Scan farthest-first so the nearest requester wins.
  always_comb begin
    idx     = '0;
    pick_o  = '0;
    valid_o = |req_i;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last_i) + k) % N);
      if (req_i[idx]) pick_o = idx;
    end
  end

endmodule

// File: rtl/pi1_rr_arbiter.sv
// pi1 round-robin arbiter: shares one pi1 slave among masters
// and steers each response back to the master that issued it.
module pi1_rr_arbiter
  import pi1_rr_arbiter_pkg::*;
#(
  parameter int MASTERCOUNT = 4,
  parameter int ARCHBITSZ   = 16
) (
  input logic             clk_i,
  input logic             rst_ni,
  pi1_rr_arbiter_if.slave bus
);

  localparam int ADDRBITSZ = addr_bits(ARCHBITSZ);
  localparam int SELBITSZ  = ARCHBITSZ / 8;
  localparam int IW        = idx_bits(MASTERCOUNT);

  logic [1:0]             op   [MASTERCOUNT];
  logic [ADDRBITSZ-1:0]   addr [MASTERCOUNT];
  logic [ARCHBITSZ-1:0]   wdat [MASTERCOUNT];
  logic [SELBITSZ-1:0]    sel  [MASTERCOUNT];
  logic [MASTERCOUNT-1:0] req;
  logic [MASTERCOUNT-1:0] acc;
  logic [MASTERCOUNT-1:0] own;
  logic [MASTERCOUNT-1:0] rdy;
  logic [IW-1:0]          pick;
  logic [IW-1:0]          owner;
  logic [IW-1:0]          last;
  logic                   valid;
  logic                   inflight;
  logic                   capture;
  logic [MASTERCOUNT-1:0] hold_vld;
  logic [ARCHBITSZ-1:0]   resp_hold [MASTERCOUNT];

  always_comb begin
    for (int i = 0; i < MASTERCOUNT; i++) begin
      op[i]   = bus.m_op_i[2*i +: 2];
      addr[i] = bus.m_addr_i[i*ADDRBITSZ +: ADDRBITSZ];
      wdat[i] = bus.m_data_i[i*ARCHBITSZ +: ARCHBITSZ];
      sel[i]  = bus.m_sel_i[i*SELBITSZ +: SELBITSZ];
      req[i]  = (op[i] != PINOOP);
      own[i]  = inflight && (owner == IW'(i));
    end
  end

  pi1_rr_arbiter_rr_pick #(
    .N  (MASTERCOUNT),
    .IW (IW)
  ) u_pick (
    .req_i   (req),
    .last_i  (last),
    .pick_o  (pick),
    .valid_o (valid)
  );

  always_comb begin
    acc = '0;
    rdy = '0;
    for (int i = 0; i < MASTERCOUNT; i++) begin
      acc[i] = rst_ni && bus.s_rdy_i && valid
             && (pick == IW'(i));
      rdy[i] = rst_ni && (req[i] ? acc[i]
             : (!own[i] || bus.s_rdy_i));
    end
  end

  always_comb begin
    bus.m_rdy_o  = rdy;
    bus.m_data_o = '0;
    for (int i = 0; i < MASTERCOUNT; i++)
      if (rdy[i])
        bus.m_data_o[i*ARCHBITSZ +: ARCHBITSZ] =
          hold_vld[i] ? resp_hold[i]
          : (own[i] ? bus.s_data_i : '0);
    bus.s_op_o   = (rst_ni && bus.s_rdy_i && valid)
                 ? op[pick] : PINOOP;
    bus.s_addr_o = addr[pick];
    bus.s_data_o = wdat[pick];
    bus.s_sel_o  = sel[pick];
  end

  // Owner lost the next grant while its result is on the bus.
  assign capture = bus.s_rdy_i && inflight
                && req[owner] && (pick != owner);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight <= 1'b0;
      owner    <= '0;
      last     <= IW'(MASTERCOUNT - 1);
      hold_vld <= '0;
      for (int i = 0; i < MASTERCOUNT; i++)
        resp_hold[i] <= '0;
    end else begin
      if (|acc) begin
        inflight <= 1'b1;
        owner    <= pick;
        last     <= pick;
      end else if (bus.s_rdy_i) begin
        inflight <= 1'b0;
      end
      for (int i = 0; i < MASTERCOUNT; i++)
        if (rdy[i]) hold_vld[i] <= 1'b0;
      if (capture) begin
        hold_vld[owner]  <= 1'b1;
        resp_hold[owner] <= bus.s_data_i;
      end
    end
  end

endmodule

// File: tb/tb_pi1_rr_arbiter.sv
// Bench for pi1_rr_arbiter: directed scenarios plus random
// traffic against a behavioural model and a pi1 slave BFM.
module tb_pi1_rr_arbiter;
  import pi1_rr_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int A  = 16;
  localparam int AB = addr_bits(A);
  localparam int SB = A / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pi1_rr_arbiter_if #(.MASTERCOUNT(N), .ARCHBITSZ(A)) bus();

  pi1_rr_arbiter #(.MASTERCOUNT(N), .ARCHBITSZ(A)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  logic [1:0]    mop   [N];
  logic [AB-1:0] maddr [N];
  logic [A-1:0]  mdat  [N];
  logic [SB-1:0] msel  [N];
  logic          s_rdy;
  logic [A-1:0]  s_data;

  always_comb begin
    bus.m_op_i   = '0;
    bus.m_addr_i = '0;
    bus.m_data_i = '0;
    bus.m_sel_i  = '0;
    for (int i = 0; i < N; i++) begin
      bus.m_op_i[2*i +: 2]     = mop[i];
      bus.m_addr_i[i*AB +: AB] = maddr[i];
      bus.m_data_i[i*A +: A]   = mdat[i];
      bus.m_sel_i[i*SB +: SB]  = msel[i];
    end
  end
  assign bus.s_rdy_i  = s_rdy;
  assign bus.s_data_i = s_data;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit           m_busy;
  int           m_owner, m_last;
  bit           stv   [N];
  logic [A-1:0] stash [N];
  // expectations of the current cycle
  logic [N-1:0]   e_req, e_rdy, dut_acc;
  bit             e_valid;
  int             e_pick;
  logic [1:0]     e_sop;
  logic [N*A-1:0] e_data;
  // end-to-end bookkeeping
  bit           outstanding [N];
  logic [A-1:0] result_of   [N];
  int           waits       [N];
  // slave BFM
  bit           pend;
  int           cnt;
  logic [A-1:0] cur;
  int           f_lat = -1;
  int           f_resp = -1;

  task automatic chk(string name, logic [127:0] act,
                     logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic drive_slave();
    s_rdy  = !pend || (cnt == 0);
    s_data = pend ? cur : A'($urandom);
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_last  = N - 1;
    for (int i = 0; i < N; i++) begin
      stv[i] = 0;
      stash[i] = '0;
      outstanding[i] = 0;
      waits[i] = 0;
    end
    pend = 0;
    cnt  = 0;
    drive_slave();
  endtask

  task automatic eval();
    int   best, d;
    logic owned;
    #1;
    e_valid = 0; e_pick = 0; e_sop = PINOOP;
    e_rdy = '0; e_data = '0; e_req = '0;
    if (!rst_n) model_reset();
    else begin
      best = N;
      for (int i = 0; i < N; i++) begin
        e_req[i] = (mop[i] != PINOOP);
        d = (i - m_last - 1 + 2*N) % N;
        if (e_req[i] && d < best) begin
          best = d; e_pick = i; e_valid = 1;
        end
      end
      if (s_rdy && e_valid) e_sop = mop[e_pick];
      for (int i = 0; i < N; i++) begin
        owned = m_busy && (m_owner == i);
        if (e_req[i])
          e_rdy[i] = s_rdy && e_valid && (e_pick == i);
        else
          e_rdy[i] = !owned || s_rdy;
        if (e_rdy[i])
          e_data[i*A +: A] = stv[i] ? stash[i]
                           : (owned ? s_data : '0);
      end
    end
    chk("s_op", bus.s_op_o, e_sop);
    chk("m_rdy", bus.m_rdy_o, e_rdy);
    chk("m_data", bus.m_data_o, e_data);
    if (rst_n && e_valid) begin
      chk("s_addr", bus.s_addr_o, maddr[e_pick]);
      chk("s_wdata", bus.s_data_o, mdat[e_pick]);
      chk("s_sel", bus.s_sel_o, msel[e_pick]);
    end
    dut_acc = e_req & bus.m_rdy_o;
    if (rst_n) for (int i = 0; i < N; i++) begin
      if (e_rdy[i] && outstanding[i])
        chk("e2e_data", bus.m_data_o[i*A +: A], result_of[i]);
      if (dut_acc[i])
        chk("fairness", waits[i] <= N - 1, 1);
      chk("hold_invariant", dut.hold_vld[i] && dut.inflight
          && (int'(dut.owner) == i), 0);
    end
  endtask

  task automatic clock_step();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else begin
      for (int i = 0; i < N; i++) begin
        if (e_rdy[i]) outstanding[i] = e_req[i];
        if (|dut_acc) begin
          if (dut_acc[i]) waits[i] = 0;
          else if (e_req[i]) waits[i]++;
        end
        if (e_rdy[i]) stv[i] = 0;
      end
      if (s_rdy && e_valid) begin
        if (m_busy && e_req[m_owner] && e_pick != m_owner) begin
          stv[m_owner]   = 1;
          stash[m_owner] = s_data;
        end
        m_busy = 1; m_owner = e_pick; m_last = e_pick;
      end else if (s_rdy) m_busy = 0;
      if (s_rdy && e_sop != PINOOP) begin
        pend = 1;
        cnt  = (f_lat >= 0) ? f_lat : int'($urandom_range(0, 3));
        cur  = (f_resp >= 0) ? A'(f_resp) : A'($urandom);
        result_of[e_pick] = cur;
      end else if (s_rdy) pend = 0;
      else cnt--;
    end
    drive_slave();
  endtask

  task automatic set_op(int i, logic [1:0] o, int ad, int dt);
    mop[i]   = o;
    maddr[i] = AB'(ad);
    mdat[i]  = A'(dt);
    msel[i]  = '1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) set_op(i, PINOOP, 0, 0);
    rst_n = 0;
    eval();
    clock_step();
    #1 rst_n = 1;
    f_lat = -1; f_resp = -1;
  endtask

  task automatic drive_masters_rand();
    for (int i = 0; i < N; i++) begin
      if (mop[i] != PINOOP && !e_rdy[i]) continue;
      if ($urandom_range(0, 99) < ((mop[i] != PINOOP) ? 55 : 35))
        set_op(i, 2'($urandom_range(1, 3)),
               int'($urandom), int'($urandom));
      else mop[i] = PINOOP;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_op(i, PINOOP, 0, 0);
    model_reset();

    // reset state
    eval();
    chk("rst_s_op", bus.s_op_o, PINOOP);
    chk("rst_rdy", bus.m_rdy_o, 4'b0000);
    chk("rst_data", bus.m_data_o, 64'h0);
    do_reset();
    eval();
    chk("idle_rdy", bus.m_rdy_o, 4'b1111);
    clock_step();

    // single master read, 3 wait cycles
    do_reset();
    f_lat = 3; f_resp = 'hBEEF;
    set_op(0, PIRDOP, 'h10, 0);
    eval();
    chk("rd_accept", bus.m_rdy_o[0], 1);
    chk("rd_addr", bus.s_addr_o, 'h10);
    clock_step();
    mop[0] = PINOOP;
    for (int c = 0; c < 3; c++) begin
      eval();
      chk("rd_wait", bus.m_rdy_o[0], 0);
      clock_step();
    end
    eval();
    chk("rd_done", bus.m_rdy_o[0], 1);
    chk("rd_data", bus.m_data_o[15:0], 16'hBEEF);
    clock_step();

    // four simultaneous writes, always-ready slave
    do_reset();
    f_lat = 0;
    for (int i = 0; i < N; i++)
      set_op(i, PIWROP, 'h100 + i, 'hA000 + i);
    for (int k = 0; k < N; k++) begin
      eval();
      chk("wr_order_rdy", bus.m_rdy_o, (1 << (k + 1)) - 1);
      chk("wr_order_data", bus.s_data_o, 'hA000 + k);
      clock_step();
      mop[k] = PINOOP;
    end

    // completion conflict: master1 loses to master2
    do_reset();
    f_lat = 2; f_resp = 'h1234;
    set_op(1, PIRDOP, 'h20, 0);
    eval();
    chk("cf_acc1", bus.m_rdy_o[1], 1);
    clock_step();
    mop[1] = PINOOP;
    for (int c = 0; c < 2; c++) begin
      eval();
      clock_step();
    end
    f_lat = 1; f_resp = 'h5555;
    set_op(1, PIRDOP, 'h24, 0);
    set_op(2, PIWROP, 'h30, 'h7777);
    eval();
    chk("cf_rdy1", bus.m_rdy_o[1], 0);
    chk("cf_rdy2", bus.m_rdy_o[2], 1);
    chk("cf_sop", bus.s_op_o, PIWROP);
    clock_step();
    mop[2] = PINOOP;
    eval();
    chk("cf_hold", dut.hold_vld[1], 1);
    chk("cf_wait1", bus.m_rdy_o[1], 0);
    clock_step();
    eval();
    chk("cf_rdy", bus.m_rdy_o[2:1], 2'b11);
    chk("cf_held", bus.m_data_o[31:16], 16'h1234);
    chk("cf_own2", bus.m_data_o[47:32], 16'h5555);
    clock_step();
    mop[1] = PINOOP;

    // wrap-around from last=2
    do_reset();
    f_lat = 0;
    set_op(2, PIWROP, 'h40, 'h1);
    eval();
    clock_step();
    mop[2] = PINOOP;
    set_op(0, PIRDOP, 'h50, 0);
    set_op(3, PIWROP, 'h60, 'h3333);
    eval();
    chk("wrap_sop3", bus.s_op_o, PIWROP);
    chk("wrap_rdy", {bus.m_rdy_o[3], bus.m_rdy_o[0]}, 2'b10);
    clock_step();
    mop[3] = PINOOP;
    eval();
    chk("wrap_sop0", bus.s_op_o, PIRDOP);
    chk("wrap_rdy0", bus.m_rdy_o[0], 1);
    clock_step();
    mop[0] = PINOOP;

    // slave stall on RWOP from master2
    do_reset();
    f_lat = 5; f_resp = 'hCAFE;
    set_op(2, PIRWOP, 'h70, 'h9);
    eval();
    chk("st_sop", bus.s_op_o, PIRWOP);
    clock_step();
    mop[2] = PINOOP;
    f_lat = 0; f_resp = -1;
    set_op(0, PIRDOP, 'h1, 0);
    set_op(1, PIRDOP, 'h2, 0);
    set_op(3, PIRDOP, 'h3, 0);
    for (int c = 0; c < 5; c++) begin
      eval();
      chk("st_noop", bus.s_op_o, PINOOP);
      chk("st_block", bus.m_rdy_o & 4'b1011, 4'b0000);
      clock_step();
    end
    eval();
    chk("st_rdy", bus.m_rdy_o, 4'b1100);
    chk("st_data", bus.m_data_o, 64'h0000_CAFE_0000_0000);
    clock_step();

    // reset while an op is in flight
    do_reset();
    f_lat = 3;
    set_op(1, PIRDOP, 'h11, 0);
    eval();
    clock_step();
    for (int i = 0; i < N; i++) set_op(i, PIRDOP, 'h80 + i, 0);
    eval();
    rst_n = 0;
    eval();
    chk("mid_rst_sop", bus.s_op_o, PINOOP);
    chk("mid_rst_rdy", bus.m_rdy_o, 4'b0000);
    chk("mid_rst_data", bus.m_data_o, 64'h0);
    clock_step();
    #1 rst_n = 1;
    f_lat = -1;
    eval();
    chk("post_rst_rdy", bus.m_rdy_o, 4'b0001);
    chk("post_rst_data", bus.m_data_o, 64'h0);
    clock_step();

    // random traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      drive_masters_rand();
      eval();
      clock_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pi1_rr_arbiter.md
Name: pi1_rr_arbiter

Overview:
- Shares one pi1 slave port between MASTERCOUNT pi1 masters. The slave is typically the pi1-to-AXI4 bridge.
- Grants are issued in round-robin order, one outstanding operation at a time.
- Routes each response back to the master that issued the operation.
- Buffers a completed response when its owner has already lost the next grant.

Parameters:
- MASTERCOUNT, 4, number of masters; must be at least 2.
- ARCHBITSZ, 16, data width. ADDRBITSZ is a localparam: ARCHBITSZ - clog2(ARCHBITSZ/8).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active-low.
- m_op_i  in  2*MASTERCOUNT  per-master op. Slice i is bits [2i+1:2i].
- m_addr_i  in  ADDRBITSZ*MASTERCOUNT  per-master word address.
- m_data_i  in  ARCHBITSZ*MASTERCOUNT  per-master write data.
- m_sel_i  in  (ARCHBITSZ/8)*MASTERCOUNT  per-master byte select.
- m_data_o  out  ARCHBITSZ*MASTERCOUNT  per-master read data.
- m_rdy_o  out  MASTERCOUNT  per-master ready.
- s_op_o  out  2  slave op.
- s_addr_o  out  ADDRBITSZ  slave address.
- s_data_o  out  ARCHBITSZ  slave write data.
- s_sel_o  out  ARCHBITSZ/8  slave byte select.
- s_data_i  in  ARCHBITSZ  slave read data.
- s_rdy_i  in  1  slave ready.

Behaviour:
- pi1 semantics:
  - An op is accepted on a cycle where rdy=1 and op != NOOP (2'b00).
  - The result of the previous op is presented on data_o in the first cycle rdy=1 after acceptance.
  - Masters hold op, addr, data and sel stable until their rdy=1.
- Registered state:
  - inflight (1b), owner (index), last (index).
  - hold_vld[MASTERCOUNT] and resp_hold[MASTERCOUNT][ARCHBITSZ].
- Reset (rst_ni low, asynchronous): inflight=0, last=MASTERCOUNT-1, hold_vld=0, resp_hold=0.
  - While rst_ni is low, s_op_o=NOOP, all m_rdy_o=0 and all m_data_o=0.
  - Reset mid-operation drops the in-flight op and any held responses. The slave is reset alongside.
- Arbitration (combinational):
  - req[i] = (m_op_i[i] != NOOP).
  - pick = first i with req[i], scanning from (last+1) mod MASTERCOUNT with wrap-around. valid = |req.
- Slave side:
  - s_op_o = (s_rdy_i && valid) ? op[pick] : NOOP.
  - s_addr_o, s_data_o and s_sel_o are always muxed from pick.
- Acceptance: acc[i] = s_rdy_i && valid && pick==i.
  - On acc: inflight<=1, owner<=pick, last<=pick.
  - s_rdy_i && !valid: inflight<=0.
- m_rdy_o[i]:
  - If req[i]: acc[i].
  - Otherwise: !(inflight && owner==i) || s_rdy_i.
  - An idle master with nothing outstanding sees rdy=1.
- m_data_o[i]:
  - Only non-zero when m_rdy_o[i]=1.
  - Value: hold_vld[i] ? resp_hold[i] : ((inflight && owner==i) ? s_data_i : 0).
- Conflict capture:
  - Condition: s_rdy_i && inflight && req[owner] && pick != owner.
  - Action: resp_hold[owner]<=s_data_i, hold_vld[owner]<=1.
  - The owner's rdy stays 0; the held data is delivered on its later accept cycle.
- Clearing: hold_vld[i]<=0 on any cycle m_rdy_o[i]=1.
- Invariant: hold_vld[i] and (inflight && owner==i) are never both 1. The bench asserts this.
- Latency:
  - Grant is zero-cycle (combinational) when the slave is idle.
  - No added register stage on the request or response paths.
- Fairness: a requesting master waits at most MASTERCOUNT-1 grants.
- Back-to-back: the owner is re-granted on its completion cycle only if it wins round-robin.

Decomposition:
- Shared package/include:
  - PINOOP/PIWROP/PIRDOP/PIRWOP constants.
  - clog2 function.
  - ADDRBITSZ derivation.
- Sub-module rr_pick:
  - Parameterised round-robin priority picker.
  - Inputs: req vector and last index. Outputs: pick index and valid.
  - Purely combinational. Reusable by other pi1 arbiters.

Test Plan:
- Single master, MASTERCOUNT=4, ARCHBITSZ=16. Master0 issues RDOP at addr 0x0010; slave returns 0xBEEF after 3 cycles -> m_rdy_o[0]=1 on accept, 0 for 3 cycles, then 1 with m_data_o[0]=0xBEEF.
- All four masters issue WROP in the same cycle with an always-ready slave -> grant order 0,1,2,3 on consecutive accepts. Each m_rdy_o rises exactly once per op; s_data_o matches each master's data.
- Master1 owns a read returning 0x1234 and issues a new RDOP on the completion cycle while master2 wins -> hold_vld[1]=1. m_rdy_o[1] stays 0 until master1 is re-picked, then m_data_o[1]=0x1234.
- last=2, requests from masters 0 and 3 -> master3 granted before master0, which confirms wrap-around.
- RWOP from master2 with a slave holding rdy low for 5 cycles -> no other master is accepted during the stall; the result returns to master2 only.
- Assert rst_ni low while an op is in flight -> immediately s_op_o=NOOP, m_rdy_o=0. After release, master0 is the first grant and no stale data appears on any m_data_o.
